// File: rtl/img_proc_pkg.sv
// Shared types and constants for the grayscale image-processing blocks.
// Contents:
//   sobel_state_t  - Sobel filter control states (IDLE, PRIME, RUN)
//   DATA_W_DEF     - default grayscale pixel width
//   IMG_WIDTH_DEF  - default pixels per grayscale row
//   SAT_MAX        - largest edge magnitude representable on a 12-bit output
package img_proc_pkg;

    localparam int DATA_W_DEF    = 12;
    localparam int IMG_WIDTH_DEF = 640;
    localparam int SAT_MAX       = 4095;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } sobel_state_t;

endpackage

// File: rtl/sobel_edge_filter_if.sv
// Pixel-in / edge-out bundle for sobel_edge_filter.
//   iGRAY/iGVAL/iSOF : grayscale pixel stream from the converter
//   oEDGE/oEVAL      : edge magnitude and its valid strobe
//   oX/oY            : window-centre coordinates of oEDGE
// modport master: stream producer / result consumer (testbench, upstream glue)
// modport slave : the filter itself
interface sobel_edge_filter_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] iGRAY;
    logic              iGVAL;
    logic              iSOF;
    logic [DATA_W-1:0] oEDGE;
    logic              oEVAL;
    logic [11:0]       oX;
    logic [10:0]       oY;

    modport master (
        output iGRAY, iGVAL, iSOF,
        input  oEDGE, oEVAL, oX, oY
    );

    modport slave (
        input  iGRAY, iGVAL, iSOF,
        output oEDGE, oEVAL, oX, oY
    );
endinterface

// File: rtl/sobel_edge_filter_gray_line_buffer.sv
// gray_line_buffer: one row of grayscale pixels, addressed by column.
// Ports:
//   clk   - clock
//   clken - write enable (one pixel beat)
//   addr  - column index
//   din   - pixel to store at addr
//   dout  - pixel previously stored at addr (combinational read, so a
//           read and write to the same column in one beat returns old data)
module gray_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 12,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              clken,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (clken) mem[addr] <= din;
    end
endmodule

// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter: 3x3 Sobel gradient magnitude over a raster grayscale
// stream. Two line buffers hold rows r-1 and r-2; a 3x3 window shifts on
// every valid pixel. Result = |Gx|+|Gy| saturated to 12 bits, tagged with
// the window-centre coordinate, two cycles after the completing pixel.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - sobel_edge_filter_if.slave (pixel in, edge/coords out)
// Build option: define SOBEL_THRESH_EN to binarise the output against
// THRESH (4095 when mag >= THRESH, else 0); latency is unchanged.
module sobel_edge_filter
    import img_proc_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int THRESH    = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    sobel_edge_filter_if.slave  bus
);
    localparam int AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int STAGES = 2;
    localparam int SW     = DATA_W + 2;   // weighted 3-tap sum
    localparam int GW     = SW + 1;       // signed gradient
    localparam int MW     = GW + 1;       // |Gx|+|Gy|
    localparam logic [DATA_W-1:0] SAT = DATA_W'(SAT_MAX);
    localparam logic [MW-1:0]     THR = MW'(THRESH);
`ifdef SOBEL_THRESH_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    sobel_state_t state, state_nxt;
    logic [11:0]  col, col_nxt, cur_col;
    logic [10:0]  row, row_nxt, cur_row;
    logic         col_wrap, emit;

    // ---------------- control ----------------
    // The SOF beat itself is pixel (0,0), so it is addressed with zeroed
    // counters in the same cycle rather than waiting for the clear to land.
    always_comb begin
        cur_col   = bus.iSOF ? 12'd0 : col;
        cur_row   = bus.iSOF ? 11'd0 : row;
        col_wrap  = (cur_col == 12'(IMG_WIDTH - 1));
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        emit      = 1'b0;
        if (bus.iGVAL) begin
            if (bus.iSOF)
                state_nxt = PRIME;
            else if (state == PRIME && col_wrap && cur_row == 11'd1)
                state_nxt = RUN;
            if (state != IDLE || bus.iSOF) begin
                col_nxt = col_wrap ? 12'd0 : cur_col + 12'd1;
                row_nxt = (col_wrap && cur_row != 11'h7FF) ? cur_row + 11'd1 : cur_row;
            end
            emit = (state == RUN) && !bus.iSOF && (cur_col >= 12'd2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    // ---------------- line buffers ----------------
    // Buffer 0 holds row r-1; its old contents cascade into buffer 1 (row r-2).
    logic [1:0][DATA_W-1:0] lb_in, lb_out;
    assign lb_in[0] = bus.iGRAY;
    assign lb_in[1] = lb_out[0];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_lb
            gray_line_buffer #(
                .DEPTH  (IMG_WIDTH),
                .DATA_W (DATA_W),
                .AW     (AW)
            ) u_lb (
                .clk   (clk),
                .clken (bus.iGVAL),
                .addr  (cur_col[AW-1:0]),
                .din   (lb_in[g]),
                .dout  (lb_out[g])
            );
        end
    endgenerate

    // ---------------- S0: window ----------------
    // win[i][j]: i = row (0 oldest), j = column (0 oldest)
    logic [2:0][DATA_W-1:0]      px_in;
    logic [2:0][2:0][DATA_W-1:0] win;
    assign px_in = {bus.iGRAY, lb_out[0], lb_out[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (bus.iGVAL) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
                win[i][2] <= px_in[i];
            end
        end
    end

    // ---------------- S1: gradients ----------------
    function automatic logic [SW-1:0] wsum(input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b,
                                           input logic [DATA_W-1:0] c);
        return SW'(a) + SW'({b, 1'b0}) + SW'(c);
    endfunction

    logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;
    always_comb begin
        gx_c = $signed({1'b0, wsum(win[0][2], win[1][2], win[2][2])})
             - $signed({1'b0, wsum(win[0][0], win[1][0], win[2][0])});
        gy_c = $signed({1'b0, wsum(win[2][0], win[2][1], win[2][2])})
             - $signed({1'b0, wsum(win[0][0], win[0][1], win[0][2])});
    end

    // ---------------- S2: magnitude ----------------
    logic [GW-1:0]     ax, ay;
    logic [MW-1:0]     mag;
    logic [DATA_W-1:0] edge_c, edge_q;
    always_comb begin
        ax  = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        ay  = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        mag = {1'b0, ax} + {1'b0, ay};
        if (THR_EN)
            edge_c = (mag >= THR) ? SAT : '0;
        else
            edge_c = (mag > MW'(SAT)) ? SAT : mag[DATA_W-1:0];
    end

    // ---------------- pipeline registers ----------------
    logic [STAGES:0]       vld_pipe;
    logic [STAGES:0][11:0] x_pipe;
    logic [STAGES:0][10:0] y_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            x_pipe   <= '0;
            y_pipe   <= '0;
            gx_q     <= '0;
            gy_q     <= '0;
            edge_q   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], emit};
            if (emit) begin
                x_pipe[0] <= cur_col - 12'd1;
                y_pipe[0] <= cur_row - 11'd1;
            end
            for (int s = 1; s <= STAGES; s++) begin
                x_pipe[s] <= x_pipe[s-1];
                y_pipe[s] <= y_pipe[s-1];
            end
            gx_q   <= gx_c;
            gy_q   <= gy_c;
            edge_q <= edge_c;
        end
    end

    assign bus.oEVAL = vld_pipe[STAGES];
    assign bus.oEDGE = edge_q;
    assign bus.oX    = x_pipe[STAGES];
    assign bus.oY    = y_pipe[STAGES];
endmodule

// File: tb/tb_sobel_edge_filter.sv
// Self-checking bench for sobel_edge_filter on an 8-wide image.
// A table of whole frames (pattern, gaps, expected beat count, expected
// peak edge) is replayed in a loop; each pixel beat that completes a window
// pushes the reference result onto a scoreboard queue, and a negedge
// monitor pops and compares value, coordinates and arrival cycle.
// Hand-written sequences cover reset, data before SOF, SOF mid-row and
// reset mid-frame. Define SOBEL_THRESH_EN to check the binarised build.
module tb_sobel_edge_filter;
    import img_proc_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 12;
    localparam int TH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_edge_filter_if #(.DATA_W(DW)) bus();

    sobel_edge_filter #(
        .IMG_WIDTH (W),
        .DATA_W    (DW),
        .THRESH    (TH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int y;
        int edge_v;
        int cyc;
    } exp_t;

    typedef struct {
        int pat;
        bit gaps;
        int exp_beats;
        int exp_max;   // -1: peak not checked
    } vec_t;

    exp_t q[$];
    int   img [H][W];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   beats_seen = 0;
    int   max_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic int model(input int y, input int x);
        int gx, gy, mag;
        gx = (img[y-1][x+1] + 2*img[y][x+1] + img[y+1][x+1])
           - (img[y-1][x-1] + 2*img[y][x-1] + img[y+1][x-1]);
        gy = (img[y+1][x-1] + 2*img[y+1][x] + img[y+1][x+1])
           - (img[y-1][x-1] + 2*img[y-1][x] + img[y-1][x+1]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
        return (mag >= TH) ? 4095 : 0;
`else
        return (mag > 4095) ? 4095 : mag;
`endif
    endfunction

    function automatic void fill(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (c >= 4) ? 1000 : 0;
                    2:       img[r][c] = (r >= 1) ? 4095 : 0;
                    default: img[r][c] = int'($urandom_range(0, 4095));
                endcase
    endfunction

    // Inputs change #1 after a posedge; the beat is captured on the next
    // edge (cyc+1) and its result must be visible after edge cyc+3.
    task automatic beat(input int v, input bit sof, input int gap, input bit push,
                        input int r, input int c);
        repeat (gap) begin
            bus.iGVAL = 1'b0;
            bus.iSOF  = 1'b0;
            @(posedge clk); #1;
        end
        bus.iGRAY = DW'(v);
        bus.iGVAL = 1'b1;
        bus.iSOF  = sof;
        if (push) q.push_back('{x: c-1, y: r-1, edge_v: model(r-1, c-1), cyc: cyc+3});
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input bit gaps, input int nrows, input int last_cols);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < ((r == nrows-1) ? last_cols : W); c++) begin
                beat(img[r][c], (r == 0 && c == 0), gaps ? int'($urandom_range(0, 1)) : 0,
                     (r >= 2 && c >= 2), r, c);
            end
        end
        bus.iGVAL = 1'b0;
        bus.iSOF  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.iGVAL = 1'b0;
        bus.iSOF  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.oEVAL) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_eval: got oX=%0d oY=%0d oEDGE=%0d expected no output",
                         bus.oX, bus.oY, bus.oEDGE);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("oEDGE", int'(bus.oEDGE), e.edge_v);
                check("oX", int'(bus.oX), e.x);
                check("oY", int'(bus.oY), e.y);
                check("latency_cycle", cyc, e.cyc);
                beats_seen++;
                if (int'(bus.oEDGE) > max_seen) max_seen = int'(bus.oEDGE);
            end
        end
    end

    vec_t tbl[5];

    initial begin
        tbl[0] = '{pat: 0, gaps: 1'b0, exp_beats: 12, exp_max: 0};
`ifdef SOBEL_THRESH_EN
        tbl[1] = '{pat: 1, gaps: 1'b0, exp_beats: 12, exp_max: 4095};
        tbl[3] = '{pat: 1, gaps: 1'b1, exp_beats: 12, exp_max: 4095};
`else
        tbl[1] = '{pat: 1, gaps: 1'b0, exp_beats: 12, exp_max: 4000};
        tbl[3] = '{pat: 1, gaps: 1'b1, exp_beats: 12, exp_max: 4000};
`endif
        tbl[2] = '{pat: 2, gaps: 1'b0, exp_beats: 12, exp_max: 4095};
        tbl[4] = '{pat: 3, gaps: 1'b1, exp_beats: 12, exp_max: -1};

        bus.iGRAY = '0;
        bus.iGVAL = 1'b0;
        bus.iSOF  = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_oEVAL", int'(bus.oEVAL), 0);
        check("reset_oEDGE", int'(bus.oEDGE), 0);
        check("reset_oX", int'(bus.oX), 0);
        check("reset_oY", int'(bus.oY), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // data without SOF is ignored in IDLE
        for (int i = 0; i < 2*W+4; i++) beat(500 + 37*i, 1'b0, 0, 1'b0, 0, 0);
        idle(5);
        check("idle_no_output", beats_seen, 0);

        // table-driven frames
        for (int t = 0; t < 5; t++) begin
            fill(tbl[t].pat);
            beats_seen = 0;
            max_seen   = 0;
            send_frame(tbl[t].gaps, H, W);
            idle(6);
            check($sformatf("frame%0d_beats", t), beats_seen, tbl[t].exp_beats);
            if (tbl[t].exp_max >= 0)
                check($sformatf("frame%0d_peak", t), max_seen, tbl[t].exp_max);
            check($sformatf("frame%0d_queue_empty", t), q.size(), 0);
        end

        // SOF mid-row 2: trailing in-flight results drain, then nothing
        // until row 2 col 2 of the new frame
        fill(3);
        beats_seen = 0;
        send_frame(1'b0, 3, 5);
        fill(1);
        send_frame(1'b0, H, W);
        idle(6);
        check("sof_midrow_beats", beats_seen, 3 + 12);
        check("sof_midrow_queue_empty", q.size(), 0);

        // reset mid-frame with results in flight
        fill(1);
        send_frame(1'b0, 3, 6);
        rst_n = 1'b0;
        #1;
        check("midreset_oEVAL", int'(bus.oEVAL), 0);
        check("midreset_oEDGE", int'(bus.oEDGE), 0);
        check("midreset_oX", int'(bus.oX), 0);
        check("midreset_oY", int'(bus.oY), 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        beats_seen = 0;
        idle(6);
        check("post_reset_quiet", beats_seen, 0);

        // recovery frame after reset
        fill(2);
        send_frame(1'b1, H, W);
        idle(6);
        check("recovery_beats", beats_seen, 12);
        check("recovery_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end
endmodule
